// File: rtl/rv_ctrl_pkg.sv
// Shared encodings for the RV32I multi-cycle controller, imm_gen and datapath muxes.
package rv_ctrl_pkg;

    // Controller state encoding
    typedef enum logic [3:0] {
        ST_FETCH    = 4'd0,
        ST_DECODE   = 4'd1,
        ST_MEMADR   = 4'd2,
        ST_MEMREAD  = 4'd3,
        ST_MEMWB    = 4'd4,
        ST_MEMWRITE = 4'd5,
        ST_EXECR    = 4'd6,
        ST_EXECI    = 4'd7,
        ST_ALUWB    = 4'd8,
        ST_BEQ      = 4'd9,
        ST_TRAP     = 4'd10
    } state_t;

    // Supported major opcodes
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    // Immediate type for imm_gen
    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;

    // Result mux
    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_RDATA  = 2'b01;
    localparam logic [1:0] RES_ALURES = 2'b10;

    // ALU operand A mux
    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;

    // ALU operand B mux
    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    // ALU operation
    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    // Main-controller request to the ALU decoder
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    // Immediate type from the opcode alone; 2'b11 is never produced.
    function automatic logic [1:0] imm_src_of(input logic [6:0] op);
        logic [1:0] v;
        v = IMM_I;
        if (op == OP_STORE) v = IMM_S;
        else if (op == OP_BRANCH) v = IMM_B;
        return v;
    endfunction

endpackage

// File: rtl/alu_decoder.sv
// Combinational ALU decoder: maps the controller's alu_op and the funct fields to an ALU operation.
module alu_decoder
    import rv_ctrl_pkg::*;
(
    input  logic [1:0] i_alu_op,
    input  logic [2:0] i_funct3,
    input  logic       i_funct7b5,
    input  logic       i_op_b5,
    output logic [2:0] o_alu_control,
    output logic       o_illegal
);

    logic [2:0] w_funct_ctrl;
    logic       w_funct_ok;

    // funct3 legality is reported independently of alu_op so DECODE can use it to trap early
    always_comb begin
        w_funct_ctrl = ALU_ADD;
        w_funct_ok   = 1'b1;
        case (i_funct3)
            3'b000:  w_funct_ctrl = (i_funct7b5 && i_op_b5) ? ALU_SUB : ALU_ADD;
            3'b010:  w_funct_ctrl = ALU_SLT;
            3'b110:  w_funct_ctrl = ALU_OR;
            3'b111:  w_funct_ctrl = ALU_AND;
            default: w_funct_ok   = 1'b0;
        endcase

        o_alu_control = ALU_ADD;
        case (i_alu_op)
            ALUOP_ADD:   o_alu_control = ALU_ADD;
            ALUOP_SUB:   o_alu_control = ALU_SUB;
            ALUOP_FUNCT: o_alu_control = w_funct_ctrl;
            default:     o_alu_control = ALU_ADD;
        endcase

        o_illegal = !w_funct_ok || (i_alu_op == 2'b11);
    end

endmodule

// File: rtl/mc_control_fsm.sv
// Multi-cycle RV32I main controller (Moore FSM, mem_ready/zero as the only Mealy terms).
//
// state    | meaning
// FETCH    | read instruction at PC, PC <= PC+4 when memory completes
// DECODE   | compute branch target old PC + imm, select next state by opcode
// MEMADR   | rs1 + imm for lw/sw
// MEMREAD  | load access, waits for mem_ready
// MEMWB    | write read data to rd
// MEMWRITE | store access, waits for mem_ready
// EXECR    | R-type ALU operation
// EXECI    | I-type ALU operation
// ALUWB    | write ALU result to rd
// BEQ      | rs1 - rs2, load PC with target when zero
// TRAP     | illegal instruction, left only by reset
module mc_control_fsm
    import rv_ctrl_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [6:0]       opcode,
    input  logic [2:0]       funct3,
    input  logic             funct7b5,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             pc_write,
    output logic             adr_src,
    output logic             mem_write,
    output logic             ir_write,
    output logic [1:0]       result_src,
    output logic [1:0]       alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       imm_src,
    output logic [2:0]       alu_control,
    output logic             reg_write,
    output logic             trap,
    output logic [CNT_W-1:0] instret
);

    state_t           r_state;
    state_t           w_next;
    logic             r_trap;
    logic [CNT_W-1:0] r_instret;

    logic [1:0]       w_alu_op;
    logic             w_funct_illegal;
    logic             w_retire;
    logic             w_pc_write;
    logic             w_ir_write;
    logic             w_mem_write;
    logic             w_reg_write;

    alu_decoder u_alu_decoder (
        .i_alu_op      (w_alu_op),
        .i_funct3      (funct3),
        .i_funct7b5    (funct7b5),
        .i_op_b5       (opcode[5]),
        .o_alu_control (alu_control),
        .o_illegal     (w_funct_illegal)
    );

    // Next-state selection
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_FETCH:    if (mem_ready) w_next = ST_DECODE;
            ST_DECODE: begin
                case (opcode)
                    OP_LOAD, OP_STORE: w_next = ST_MEMADR;
                    OP_RTYPE:          w_next = w_funct_illegal ? ST_TRAP : ST_EXECR;
                    OP_ITYPE:          w_next = w_funct_illegal ? ST_TRAP : ST_EXECI;
                    OP_BRANCH:         w_next = (funct3 == 3'b000) ? ST_BEQ : ST_TRAP;
                    default:           w_next = ST_TRAP;
                endcase
            end
            ST_MEMADR:   w_next = opcode[5] ? ST_MEMWRITE : ST_MEMREAD;
            ST_MEMREAD:  if (mem_ready) w_next = ST_MEMWB;
            ST_MEMWB:    w_next = ST_FETCH;
            ST_MEMWRITE: if (mem_ready) w_next = ST_FETCH;
            ST_EXECR:    w_next = ST_ALUWB;
            ST_EXECI:    w_next = ST_ALUWB;
            ST_ALUWB:    w_next = ST_FETCH;
            ST_BEQ:      w_next = ST_FETCH;
            ST_TRAP:     w_next = ST_TRAP;
            default:     w_next = ST_FETCH;
        endcase
    end

    // An instruction retires on the edge that returns to FETCH from a final state
    always_comb begin
        w_retire = 1'b0;
        case (r_state)
            ST_MEMWB, ST_ALUWB, ST_BEQ: w_retire = 1'b1;
            ST_MEMWRITE:                w_retire = mem_ready;
            default:                    w_retire = 1'b0;
        endcase
    end

    // Datapath selects and raw strobes per state
    always_comb begin
        adr_src     = 1'b0;
        result_src  = RES_ALUOUT;
        alu_src_a   = SRCA_PC;
        alu_src_b   = SRCB_RS2;
        w_alu_op    = ALUOP_ADD;
        w_pc_write  = 1'b0;
        w_ir_write  = 1'b0;
        w_mem_write = 1'b0;
        w_reg_write = 1'b0;
        case (r_state)
            ST_FETCH: begin
                alu_src_a  = SRCA_PC;
                alu_src_b  = SRCB_FOUR;
                result_src = RES_ALURES;
                w_ir_write = mem_ready;
                w_pc_write = mem_ready;
            end
            ST_DECODE: begin
                alu_src_a = SRCA_OLDPC;
                alu_src_b = SRCB_IMM;
            end
            ST_MEMADR: begin
                alu_src_a = SRCA_RS1;
                alu_src_b = SRCB_IMM;
            end
            ST_MEMREAD: adr_src = 1'b1;
            ST_MEMWB: begin
                result_src  = RES_RDATA;
                w_reg_write = 1'b1;
            end
            ST_MEMWRITE: begin
                adr_src     = 1'b1;
                w_mem_write = 1'b1;
            end
            ST_EXECR: begin
                alu_src_a = SRCA_RS1;
                alu_src_b = SRCB_RS2;
                w_alu_op  = ALUOP_FUNCT;
            end
            ST_EXECI: begin
                alu_src_a = SRCA_RS1;
                alu_src_b = SRCB_IMM;
                w_alu_op  = ALUOP_FUNCT;
            end
            ST_ALUWB: begin
                result_src  = RES_ALUOUT;
                w_reg_write = 1'b1;
            end
            ST_BEQ: begin
                alu_src_a  = SRCA_RS1;
                alu_src_b  = SRCB_RS2;
                w_alu_op   = ALUOP_SUB;
                result_src = RES_ALUOUT;
                w_pc_write = zero;
            end
            default: ;
        endcase
    end

    // Architectural write strobes are suppressed for the whole reset window
    always_comb begin
        pc_write  = w_pc_write  & ~reset;
        ir_write  = w_ir_write  & ~reset;
        mem_write = w_mem_write & ~reset;
        reg_write = w_reg_write & ~reset;
        imm_src   = imm_src_of(opcode);
        trap      = r_trap;
        instret   = r_instret;
    end

    // State, sticky trap flag and retired-instruction counter
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= ST_FETCH;
            r_trap    <= 1'b0;
            r_instret <= '0;
        end else begin
            r_state <= w_next;
            if (w_next == ST_TRAP) r_trap <= 1'b1;
            if (w_retire) r_instret <= r_instret + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

endmodule
